// File: rtl/arb_out_queue_pkg.sv
// Shared definitions for the arbiter output queue: default sizing and the
// {tag, bits} entry record used on the arbiter side of the link.
package arb_out_queue_pkg;

  localparam int DEPTH_DEF  = 4;
  localparam int DATA_W_DEF = 8;
  localparam int TAG_W_DEF  = 2;

  // One buffered beat: source tag from the arbiter plus its payload.
  typedef struct packed {
    logic [TAG_W_DEF-1:0]  tag;
    logic [DATA_W_DEF-1:0] bits;
  } entry_t;

  // Occupancy counter width for a queue of the given depth (0..depth).
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/arb_out_queue_tag_occupancy.sv
// Per-source occupancy counters: one counter per tag value, tracking how many
// entries carrying that tag are currently buffered in the queue.
module tag_occupancy
  import arb_out_queue_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF,
  parameter int CNT_W = 3,
  localparam int NTAG = 1 << TAG_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enq_fire,
  input  logic [TAG_W-1:0]            enq_tag,
  input  logic                        deq_fire,
  input  logic [TAG_W-1:0]            deq_tag,
  output logic [NTAG-1:0][CNT_W-1:0]  counts
);

  logic [NTAG-1:0] inc;
  logic [NTAG-1:0] dec;

  // Decode which counter gains and which loses an entry this cycle.
  always_comb begin
    inc = '0;
    dec = '0;
    for (int k = 0; k < NTAG; k++) begin
      inc[k] = enq_fire && (enq_tag == TAG_W'(k));
      dec[k] = deq_fire && (deq_tag == TAG_W'(k));
    end
  end

  // Counter update; an enqueue and dequeue on the same tag cancel out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counts <= '0;
    end else begin
      for (int k = 0; k < NTAG; k++) begin
        case ({inc[k], dec[k]})
          2'b10:   counts[k] <= counts[k] + CNT_W'(1);
          2'b01:   counts[k] <= counts[k] - CNT_W'(1);
          default: counts[k] <= counts[k];
        endcase
      end
    end
  end

endmodule

// File: rtl/arb_out_queue.sv
// Output queue behind the arbiter: a plain registered FIFO of {tag, bits}
// entries with no flow-through and no pipe bypass, plus per-tag occupancy.
module arb_out_queue
  import arb_out_queue_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = occ_width(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_enq_valid,
  output logic              io_enq_ready,
  input  logic [DATA_W-1:0] io_enq_bits,
  input  logic [TAG_W-1:0]  io_enq_tag,
  output logic              io_deq_valid,
  input  logic              io_deq_ready,
  output logic [DATA_W-1:0] io_deq_bits,
  output logic [TAG_W-1:0]  io_deq_tag,
  output logic [CNT_W-1:0]  io_count,
  output logic [CNT_W-1:0]  io_tag_count_0,
  output logic [CNT_W-1:0]  io_tag_count_1,
  output logic [CNT_W-1:0]  io_tag_count_2,
  output logic [CNT_W-1:0]  io_tag_count_3
);

  localparam int NTAG = 1 << TAG_W;

  // Same layout as entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] bits;
  } slot_t;

  slot_t                      mem [DEPTH];
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic                       enq_fire;
  logic                       deq_fire;
  logic [NTAG-1:0][CNT_W-1:0] tag_counts;
  logic [3:0][CNT_W-1:0]      tag_cnt_vis;

  // Ready/valid depend only on the registered count, never on the far side.
  assign io_enq_ready = (io_count < CNT_W'(DEPTH));
  assign io_deq_valid = (io_count != '0);
  assign enq_fire     = io_enq_valid && io_enq_ready;
  assign deq_fire     = io_deq_valid && io_deq_ready;

  assign io_deq_bits  = mem[rd_ptr].bits;
  assign io_deq_tag   = mem[rd_ptr].tag;

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      mem[wr_ptr] <= '{tag: io_enq_tag, bits: io_enq_bits};
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (enq_fire) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq_fire) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Occupancy register; simultaneous enqueue and dequeue leave it unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      io_count <= '0;
    end else begin
      case ({enq_fire, deq_fire})
        2'b10:   io_count <= io_count + CNT_W'(1);
        2'b01:   io_count <= io_count - CNT_W'(1);
        default: io_count <= io_count;
      endcase
    end
  end

  tag_occupancy #(
    .TAG_W (TAG_W),
    .CNT_W (CNT_W)
  ) u_tag_occupancy (
    .clk      (clk),
    .reset    (reset),
    .enq_fire (enq_fire),
    .enq_tag  (io_enq_tag),
    .deq_fire (deq_fire),
    .deq_tag  (io_deq_tag),
    .counts   (tag_counts)
  );

  // Map the per-tag counters onto the four fixed output ports.
  always_comb begin
    tag_cnt_vis = '0;
    for (int k = 0; k < NTAG && k < 4; k++) begin
      tag_cnt_vis[k] = tag_counts[k];
    end
  end

  assign io_tag_count_0 = tag_cnt_vis[0];
  assign io_tag_count_1 = tag_cnt_vis[1];
  assign io_tag_count_2 = tag_cnt_vis[2];
  assign io_tag_count_3 = tag_cnt_vis[3];

endmodule

// File: doc/arb_out_queue.md
ARB_OUT_QUEUE -- requirements
Module: arb_out_queue

Interface
REQ-001 SHALL have parameter DEPTH, 4, number of buffered entries (power of two, >= 2).
REQ-002 SHALL have parameter DATA_W, 8, payload width.
REQ-003 SHALL have parameter TAG_W, 2, source-tag width (matches arbiter chosen width).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low (0 = reset asserted).
REQ-006 io_enq_valid  input  1  upstream (arbiter output) has a beat.
REQ-007 io_enq_ready  output  1  queue accepts a beat this cycle.
REQ-008 io_enq_bits  input  DATA_W  payload from arbiter io_out_bits.
REQ-009 io_enq_tag  input  TAG_W  source index from arbiter io_chosen.
REQ-010 io_deq_valid  output  1  head entry available.
REQ-011 io_deq_ready  input  1  downstream consumes head.
REQ-012 io_deq_bits  output  DATA_W  head payload.
REQ-013 io_deq_tag  output  TAG_W  head source tag.
REQ-014 io_count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-015 io_tag_count_0..3  output  log2(DEPTH)+1 each  occupancy per source tag.

Function
REQ-016 Enqueue fire SHALL be io_enq_valid & io_enq_ready; dequeue fire SHALL be io_deq_valid & io_deq_ready.
REQ-017 io_enq_ready SHALL be 1 iff io_count < DEPTH (not dependent on io_deq_ready; no pipe bypass).
REQ-018 io_deq_valid SHALL be 1 iff io_count > 0 (no flow-through; enqueue-to-dequeue latency is 1 cycle minimum).
REQ-019 io_deq_bits/io_deq_tag SHALL come from the head storage entry, combinationally from read pointer; undefined-content entries never presented (valid low when empty).
REQ-020 Storage SHALL be DEPTH entries of {tag, bits} with read and write pointers of log2(DEPTH) bits wrapping DEPTH-1 -> 0.
REQ-021 Enqueue fire SHALL write {io_enq_tag, io_enq_bits} at write pointer and increment it; dequeue fire SHALL increment read pointer.
REQ-022 io_count SHALL be a register: +1 on enqueue only, -1 on dequeue only, unchanged on both or neither.
REQ-023 Simultaneous enqueue and dequeue when 0 < count < DEPTH SHALL leave count unchanged and move both pointers.
REQ-024 When full, io_enq_ready = 0 even if io_deq_ready = 1; a dequeue that cycle frees a slot visible next cycle.
REQ-025 When empty, an enqueue SHALL not be visible on io_deq_* until the following cycle.
REQ-026 io_tag_count_k SHALL +1 on enqueue with tag k, -1 on dequeue of head tag k, net 0 when both hit k in same cycle; sum of all tag counts SHALL always equal io_count.
REQ-027 Data ordering SHALL be strict FIFO across all tags.

Reset
REQ-028 reset low SHALL asynchronously clear pointers, io_count and all io_tag_count_k to 0, forcing io_deq_valid = 0 and io_enq_ready = 1.
REQ-029 Storage contents SHALL not be reset; reset mid-operation SHALL discard all buffered entries.
REQ-030 Deassertion SHALL be honoured on clk rising edge; first enqueue possible in the first cycle after release.

Structure
REQ-031 DEPTH, DATA_W, TAG_W defaults and the {tag, bits} entry record SHALL live in the shared stdlib package used with the arbiter.
REQ-032 Per-tag counters SHALL be one sub-module, tag_occupancy, instantiated once with 2^TAG_W counters; queue core stays in arb_out_queue.

Verification
REQ-033 Empty, enq (bits 0x11, tag 2), deq_ready=1 -> deq_valid=0 that cycle, next cycle deq_bits=0x11, tag=2, count=1, tag_count_2=1.
REQ-034 Enqueue 0xA0..0xA3 with deq_ready=0 -> count=4, enq_ready=0; fifth beat 0xA4 held and not stored.
REQ-035 Full, deq_ready=1 and enq_valid=1 -> only dequeue fires (0xA0 out), count=3, enq_ready=1 next cycle.
REQ-036 Count=2, simultaneous enq (tag 1) and deq (head tag 1) -> count=2, tag_count_1 unchanged; 10 wrapped cycles preserve order.
REQ-037 Reset low with count=3 -> same-cycle deq_valid=0, count=0, all tag counts 0, enq_ready=1.
REQ-038 Random enq/deq 2000 cycles against reference FIFO model -> data/tag order match, per-tag sums equal io_count every cycle.
